// File: rtl/vga_timing_pkg.sv
// Purpose: shared constants and helpers for the VGA raster timing generator.
//   - Default 640x480@60 horizontal/vertical timing set
//   - axis_total(): line/frame length from active + porches + pulse
//   - axis_width(): counter width able to hold 0..total-1
//   - Sync polarity constants
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACT    = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACT    = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_LINE_IRQ = 479;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // Full period of one axis (pixels per line or lines per frame).
  function automatic int unsigned axis_total(input int unsigned act,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  // Bits needed for a counter running 0..total-1.
  function automatic int unsigned axis_width(input int unsigned total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Purpose: one raster axis (H or V) -- a wrapping counter plus region decode.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   adv          advance the counter this cycle
//   cnt          current position 0..TOT-1
//   wrap_c       adv while at TOT-1 (carry into the next axis)
//   active_c     position is inside the visible region
//   sync_c       position is inside the sync pulse
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACT  = DEF_H_ACT,
  parameter int unsigned FP   = DEF_H_FP,
  parameter int unsigned SYNC = DEF_H_SYNC,
  parameter int unsigned BP   = DEF_H_BP,
  parameter int unsigned W    = axis_width(axis_total(ACT, FP, SYNC, BP))
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         wrap_c,
  output logic         active_c,
  output logic         sync_c
);

  localparam int unsigned TOT      = axis_total(ACT, FP, SYNC, BP);
  localparam logic [W-1:0] LAST     = W'(TOT - 1);
  localparam logic [W-1:0] ACT_END  = W'(ACT);
  localparam logic [W-1:0] SYNC_BEG = W'(ACT + FP);
  localparam logic [W-1:0] SYNC_END = W'(ACT + FP + SYNC);

  // Every region must be at least one unit wide.
  if (ACT == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_param
    $error("vga_axis_counter: zero-width timing region");
  end

  assign wrap_c   = adv && (cnt == LAST);
  assign active_c = (cnt < ACT_END);
  assign sync_c   = (cnt >= SYNC_BEG) && (cnt < SYNC_END);

  // Position counter, wraps to 0 after TOT-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= wrap_c ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: parametrised VGA raster timing generator. Free-running H/V counters
//   decoded into registered syncs, active-video enable, column/row and a
//   frame-start strobe, all with one enabled cycle of latency.
// Ports:
//   CLK            pixel clock
//   i_Rst_n        asynchronous active-low reset
//   i_Pix_En       pixel clock-enable; counters and outputs hold while low
//   o_H_Sync       horizontal sync (asserted level = SYNC_POL)
//   o_V_Sync       vertical sync (asserted level = SYNC_POL)
//   o_Active       visible-area enable
//   o_Col, o_Row   position aligned with o_Active and the syncs
//   o_Frame_Start  one-enabled-cycle pulse at col 0 / row 0
//   o_Line_Match   one-enabled-cycle pulse at col 0 of row LINE_IRQ
// Build option: define VGA_LINE_IRQ_EN to add o_Line_Match and LINE_IRQ.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACT    = DEF_H_ACT,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACT    = DEF_V_ACT,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
`ifdef VGA_LINE_IRQ_EN
  parameter int unsigned LINE_IRQ = DEF_LINE_IRQ,
`endif
  parameter logic        SYNC_POL = SYNC_ACTIVE_LOW,
  localparam int unsigned HW = axis_width(axis_total(H_ACT, H_FP, H_SYNC, H_BP)),
  localparam int unsigned VW = axis_width(axis_total(V_ACT, V_FP, V_SYNC, V_BP))
) (
  input  logic          CLK,
  input  logic          i_Rst_n,
  input  logic          i_Pix_En,
  output logic          o_H_Sync,
  output logic          o_V_Sync,
  output logic          o_Active,
  output logic [HW-1:0] o_Col,
  output logic [VW-1:0] o_Row,
  output logic          o_Frame_Start
`ifdef VGA_LINE_IRQ_EN
 ,output logic          o_Line_Match
`endif
);

  localparam logic SYNC_IDLE = (SYNC_POL == SYNC_ACTIVE_LOW) ? SYNC_ACTIVE_HIGH
                                                             : SYNC_ACTIVE_LOW;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap_c, h_act_c, h_sync_c;
  logic          v_wrap_unused, v_act_c, v_sync_c;

  // Horizontal axis: advances on every enabled pixel.
  vga_axis_counter #(
    .ACT (H_ACT), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .W (HW)
  ) u_h_axis (
    .clk      (CLK),
    .rst_n    (i_Rst_n),
    .adv      (i_Pix_En),
    .cnt      (h_cnt),
    .wrap_c   (h_wrap_c),
    .active_c (h_act_c),
    .sync_c   (h_sync_c)
  );

  // Vertical axis: advances only when the line wraps.
  vga_axis_counter #(
    .ACT (V_ACT), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .W (VW)
  ) u_v_axis (
    .clk      (CLK),
    .rst_n    (i_Rst_n),
    .adv      (h_wrap_c),
    .cnt      (v_cnt),
    .wrap_c   (v_wrap_unused),
    .active_c (v_act_c),
    .sync_c   (v_sync_c)
  );

  // Output registers: decode of the current position, loaded as it advances.
  always_ff @(posedge CLK or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_H_Sync      <= SYNC_IDLE;
      o_V_Sync      <= SYNC_IDLE;
      o_Active      <= 1'b0;
      o_Col         <= '0;
      o_Row         <= '0;
      o_Frame_Start <= 1'b0;
    end else if (i_Pix_En) begin
      o_H_Sync      <= h_sync_c ? SYNC_POL : SYNC_IDLE;
      o_V_Sync      <= v_sync_c ? SYNC_POL : SYNC_IDLE;
      o_Active      <= h_act_c && v_act_c;
      o_Col         <= h_cnt;
      o_Row         <= v_cnt;
      o_Frame_Start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

`ifdef VGA_LINE_IRQ_EN
  // Line interrupt: first pixel of row LINE_IRQ.
  always_ff @(posedge CLK or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Line_Match <= 1'b0;
    end else if (i_Pix_En) begin
      o_Line_Match <= (h_cnt == '0) && (v_cnt == VW'(LINE_IRQ));
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance for line-level timing and a tiny
// instance (H=4/1/2/1, V=3/1/1/1, active-high syncs) for whole-frame checks.
module tb_vga_timing_gen;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst_n;
  logic       en_d, en_s;
  logic       hs_d, vs_d, act_d, fs_d;
  logic [9:0] col_d, row_d;
  logic       hs_s, vs_s, act_s, fs_s;
  logic [2:0] col_s, row_s;
`ifdef VGA_LINE_IRQ_EN
  logic       lm_d, lm_s;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  vga_timing_gen dut_d (
    .CLK           (CLK),
    .i_Rst_n       (rst_n),
    .i_Pix_En      (en_d),
    .o_H_Sync      (hs_d),
    .o_V_Sync      (vs_d),
    .o_Active      (act_d),
    .o_Col         (col_d),
    .o_Row         (row_d),
    .o_Frame_Start (fs_d)
`ifdef VGA_LINE_IRQ_EN
   ,.o_Line_Match  (lm_d)
`endif
  );

  vga_timing_gen #(
    .H_ACT (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACT (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
`ifdef VGA_LINE_IRQ_EN
    .LINE_IRQ (2),
`endif
    .SYNC_POL (1'b1)
  ) dut_s (
    .CLK           (CLK),
    .i_Rst_n       (rst_n),
    .i_Pix_En      (en_s),
    .o_H_Sync      (hs_s),
    .o_V_Sync      (vs_s),
    .o_Active      (act_s),
    .o_Col         (col_s),
    .o_Row         (row_s),
    .o_Frame_Start (fs_s)
`ifdef VGA_LINE_IRQ_EN
   ,.o_Line_Match  (lm_s)
`endif
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_d = 1'b0; en_s = 1'b0;
    repeat (3) step();
    n_cmp++; if ({hs_d, vs_d, act_d, fs_d} !== 4'b1100) begin n_bad++; $display("FAIL reset_d_flags: got %b want 1100", {hs_d, vs_d, act_d, fs_d}); end
    n_cmp++; if ({col_d, row_d} !== 20'd0) begin n_bad++; $display("FAIL reset_d_pos: got col %0d row %0d want 0/0", col_d, row_d); end
    n_cmp++; if ({hs_s, vs_s, act_s, fs_s} !== 4'b0000) begin n_bad++; $display("FAIL reset_s_flags: got %b want 0000", {hs_s, vs_s, act_s, fs_s}); end
    n_cmp++; if ({col_s, row_s} !== 6'd0) begin n_bad++; $display("FAIL reset_s_pos: got col %0d row %0d want 0/0", col_s, row_s); end
`ifdef VGA_LINE_IRQ_EN
    n_cmp++; if ({lm_d, lm_s} !== 2'b00) begin n_bad++; $display("FAIL reset_line_match: got %b want 00", {lm_d, lm_s}); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_first_cycles();
    en_d = 1'b1;
    step();
    n_cmp++; if ({act_d, fs_d, hs_d} !== 3'b111) begin n_bad++; $display("FAIL first_flags: got act/fs/hs %b want 111", {act_d, fs_d, hs_d}); end
    n_cmp++; if (col_d !== 10'd0 || row_d !== 10'd0) begin n_bad++; $display("FAIL first_pos: got col %0d row %0d want 0/0", col_d, row_d); end
    step();
    n_cmp++; if (fs_d !== 1'b0 || col_d !== 10'd1) begin n_bad++; $display("FAIL second_cycle: got fs %b col %0d want 0 / 1", fs_d, col_d); end
  endtask

  task automatic test_hsync_line();
    int low_cnt = 0, first_low = -1, high_after = -1, first_inact = -1, vs_low = 0;
    for (int c = 2; c < 800; c++) begin
      step();
      if (hs_d === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = int'(col_d);
      end else if (first_low >= 0 && high_after < 0) begin
        high_after = int'(col_d);
      end
      if (act_d === 1'b0 && first_inact < 0) first_inact = int'(col_d);
      if (vs_d !== 1'b1) vs_low++;
    end
    n_cmp++; if (low_cnt != 96) begin n_bad++; $display("FAIL hsync_width: got %0d want 96", low_cnt); end
    n_cmp++; if (first_low != 656) begin n_bad++; $display("FAIL hsync_start: got col %0d want 656", first_low); end
    n_cmp++; if (high_after != 752) begin n_bad++; $display("FAIL hsync_end: got col %0d want 752", high_after); end
    n_cmp++; if (first_inact != 640) begin n_bad++; $display("FAIL active_end: got col %0d want 640", first_inact); end
    n_cmp++; if (vs_low != 0) begin n_bad++; $display("FAIL vsync_row0: got %0d asserted cycles want 0", vs_low); end
    n_cmp++; if (col_d !== 10'd799 || row_d !== 10'd0) begin n_bad++; $display("FAIL line_end: got col %0d row %0d want 799/0", col_d, row_d); end
  endtask

  task automatic test_line_wrap();
    step();
    n_cmp++; if (col_d !== 10'd0 || row_d !== 10'd1 || act_d !== 1'b1 || fs_d !== 1'b0) begin n_bad++; $display("FAIL wrap_row1: got col %0d row %0d act %b fs %b want 0/1/1/0", col_d, row_d, act_d, fs_d); end
    repeat (3999) step();
    n_cmp++; if (col_d !== 10'd799 || row_d !== 10'd5 || act_d !== 1'b0) begin n_bad++; $display("FAIL row5_end: got col %0d row %0d act %b want 799/5/0", col_d, row_d, act_d); end
    step();
    n_cmp++; if (col_d !== 10'd0 || row_d !== 10'd6 || act_d !== 1'b1 || hs_d !== 1'b1) begin n_bad++; $display("FAIL wrap_row6: got col %0d row %0d act %b hs %b want 0/6/1/1", col_d, row_d, act_d, hs_d); end
  endtask

  task automatic test_pix_en_toggle();
    for (int i = 1; i <= 10; i++) begin
      en_d = 1'b0;
      step();
      n_cmp++; if (col_d !== 10'(i - 1) || row_d !== 10'd6) begin n_bad++; $display("FAIL en_hold: got col %0d row %0d want %0d/6", col_d, row_d, i - 1); end
      en_d = 1'b1;
      step();
      n_cmp++; if (col_d !== 10'(i) || act_d !== 1'b1) begin n_bad++; $display("FAIL en_advance: got col %0d act %b want %0d/1", col_d, act_d, i); end
    end
  endtask

  task automatic test_async_reset_d();
    repeat (190) step();
    n_cmp++; if (col_d !== 10'd200 || row_d !== 10'd6) begin n_bad++; $display("FAIL pre_reset_pos: got col %0d row %0d want 200/6", col_d, row_d); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({col_d, row_d} !== 20'd0 || {hs_d, vs_d, act_d, fs_d} !== 4'b1100) begin n_bad++; $display("FAIL async_reset_d: got col %0d row %0d flags %b want 0/0 1100", col_d, row_d, {hs_d, vs_d, act_d, fs_d}); end
    en_d = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_small_frames();
    int fs_cnt = 0, vs_cnt = 0, hs_cnt = 0;
    en_s = 1'b1;
    for (int k = 0; k < 96; k++) begin
      int pos, c, r;
      logic e_act, e_hs, e_vs, e_fs;
      step();
      pos = k % 48; c = pos % 8; r = pos / 8;
      e_act = (c < 4) && (r < 3);
      e_hs  = (c == 5) || (c == 6);
      e_vs  = (r == 4);
      e_fs  = (pos == 0);
      if (fs_s === 1'b1) fs_cnt++;
      if (vs_s === 1'b1) vs_cnt++;
      if (hs_s === 1'b1) hs_cnt++;
      n_cmp++; if (col_s !== 3'(c) || row_s !== 3'(r)) begin n_bad++; $display("FAIL small_pos k=%0d: got col %0d row %0d want %0d/%0d", k, col_s, row_s, c, r); end
      n_cmp++; if ({act_s, hs_s, vs_s, fs_s} !== {e_act, e_hs, e_vs, e_fs}) begin n_bad++; $display("FAIL small_flags k=%0d: got %b want %b", k, {act_s, hs_s, vs_s, fs_s}, {e_act, e_hs, e_vs, e_fs}); end
`ifdef VGA_LINE_IRQ_EN
      n_cmp++; if (lm_s !== (pos == 16)) begin n_bad++; $display("FAIL small_line_match k=%0d: got %b want %b", k, lm_s, pos == 16); end
`endif
    end
    n_cmp++; if (fs_cnt != 2) begin n_bad++; $display("FAIL small_fs_count: got %0d want 2", fs_cnt); end
    n_cmp++; if (vs_cnt != 16) begin n_bad++; $display("FAIL small_vs_count: got %0d want 16", vs_cnt); end
    n_cmp++; if (hs_cnt != 24) begin n_bad++; $display("FAIL small_hs_count: got %0d want 24", hs_cnt); end
  endtask

  task automatic test_small_hold();
    step();
    n_cmp++; if (fs_s !== 1'b1 || col_s !== 3'd0 || row_s !== 3'd0) begin n_bad++; $display("FAIL hold_start: got fs %b col %0d row %0d want 1/0/0", fs_s, col_s, row_s); end
    en_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (fs_s !== 1'b1 || col_s !== 3'd0 || act_s !== 1'b1) begin n_bad++; $display("FAIL hold_fs i=%0d: got fs %b col %0d act %b want 1/0/1", i, fs_s, col_s, act_s); end
    end
    en_s = 1'b1;
    step();
    n_cmp++; if (fs_s !== 1'b0 || col_s !== 3'd1) begin n_bad++; $display("FAIL hold_release: got fs %b col %0d want 0/1", fs_s, col_s); end
  endtask

  task automatic test_small_reset();
    repeat (20) step();
    n_cmp++; if (col_s !== 3'd5 || row_s !== 3'd2 || hs_s !== 1'b1 || act_s !== 1'b0) begin n_bad++; $display("FAIL small_pre_reset: got col %0d row %0d hs %b act %b want 5/2/1/0", col_s, row_s, hs_s, act_s); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({col_s, row_s} !== 6'd0 || {hs_s, vs_s, act_s, fs_s} !== 4'b0000) begin n_bad++; $display("FAIL small_async_reset: got col %0d row %0d flags %b want 0/0 0000", col_s, row_s, {hs_s, vs_s, act_s, fs_s}); end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (fs_s !== 1'b1 || act_s !== 1'b1 || {col_s, row_s} !== 6'd0) begin n_bad++; $display("FAIL small_restart: got fs %b act %b col %0d row %0d want 1/1/0/0", fs_s, act_s, col_s, row_s); end
  endtask

  initial begin
    test_reset();
    test_first_cycles();
    test_hsync_line();
    test_line_wrap();
    test_pix_en_toggle();
    test_async_reset_d();
    test_small_frames();
    test_small_hold();
    test_small_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
